// File: rtl/dmem_bus_bridge_pkg.sv
// dmem_bus_pkg: shared request type, FSM states and helpers for the data-memory bus bridge
package dmem_bus_pkg;
  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;
  localparam int DMEM_MW = DMEM_DW / 8;
  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
    logic [DMEM_MW-1:0] mask;
  } dmem_req_t;
  typedef enum logic [2:0] {IDLE, DRAIN, LD_REQ, LD_WAIT, LD_DONE} bridge_state_t;
  function automatic logic [DMEM_AW-1:0] word_addr(input logic [DMEM_AW-1:0] a);
    return {a[DMEM_AW-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/wbuf_fifo.sv
// wbuf_fifo: posted-store buffer; pointers carry one extra bit to tell full from empty
module wbuf_fifo import dmem_bus_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  dmem_req_t data_i,
  input  logic      pop_i,
  output dmem_req_t head_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int PW = $clog2(DEPTH);
  dmem_req_t mem_q [DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_i};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop_i};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
  end
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];
  assign empty_o = wr_ptr_q == rd_ptr_q;
  assign full_o  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) & (wr_ptr_q[PW] != rd_ptr_q[PW]);
endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: MEM-stage data port to valid/ready RAM bus with posted stores and blocking loads
module dmem_bus_bridge import dmem_bus_pkg::*; #(
  parameter int ADDR_WIDTH = DMEM_AW,
  parameter int DATA_WIDTH = DMEM_DW,
  parameter int MASK_WIDTH = DMEM_MW,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_rd_en,
  input  logic                  core_wr_en,
  input  logic [MASK_WIDTH-1:0] core_mask,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wr_data,
  output logic [DATA_WIDTH-1:0] core_rd_data,
  output logic                  core_stall,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_req_we,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  output logic [DATA_WIDTH-1:0] bus_req_wdata,
  output logic [MASK_WIDTH-1:0] bus_req_mask,
  input  logic                  bus_resp_valid,
  input  logic [DATA_WIDTH-1:0] bus_resp_rdata,
  output logic                  wbuf_empty
);
  bridge_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  dmem_req_t             head, push_req;
  logic                  push, pop, full, empty, is_load, ld_phase;
  // a simultaneous rd/wr request is handled as a store
  assign is_load  = core_rd_en & ~core_wr_en;
  assign push     = (state_q == IDLE) & core_wr_en & ~full;
  assign push_req = '{we: 1'b1, addr: word_addr(core_addr), wdata: core_wr_data, mask: core_mask};
  wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_req),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  // the buffer is always empty once LD_REQ is reached, so the head write and the read never compete
  assign ld_phase      = state_q == LD_REQ;
  assign bus_req_valid = ld_phase | ~empty;
  assign bus_req_we    = ~ld_phase & head.we;
  assign bus_req_addr  = ld_phase ? ld_addr_q : head.addr;
  assign bus_req_wdata = head.wdata;
  assign bus_req_mask  = ld_phase ? '1 : head.mask;
  assign pop           = ~ld_phase & ~empty & bus_req_ready;
  assign wbuf_empty    = empty;
  assign core_rd_data  = rd_data_q;
  always_comb begin
    state_d    = state_q;
    ld_addr_d  = ld_addr_q;
    rd_data_d  = rd_data_q;
    core_stall = 1'b0;
    case (state_q)
      IDLE: begin
        core_stall = is_load | (core_wr_en & full);
        if (is_load) begin
          state_d   = empty ? LD_REQ : DRAIN;
          ld_addr_d = word_addr(core_addr);
        end
      end
      DRAIN: begin
        core_stall = 1'b1;
        if (empty) state_d = LD_REQ;
      end
      LD_REQ: begin
        core_stall = 1'b1;
        if (bus_req_ready) state_d = LD_WAIT;
      end
      LD_WAIT: begin
        core_stall = 1'b1;
        if (bus_resp_valid) begin
          rd_data_d = bus_resp_rdata;
          state_d   = LD_DONE;
        end
      end
      LD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ld_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: scoreboard bench with a program-order memory model and a bus RAM agent
module tb_dmem_bus_bridge;
  logic        clk = 1'b0, rst = 1'b0;
  logic        core_rd_en = 1'b0, core_wr_en = 1'b0;
  logic [3:0]  core_mask = '0;
  logic [31:0] core_addr = '0, core_wr_data = '0, core_rd_data;
  logic        core_stall, bus_req_valid, bus_req_we, wbuf_empty;
  logic        bus_req_ready = 1'b0, bus_resp_valid = 1'b0;
  logic [31:0] bus_req_addr, bus_req_wdata, bus_resp_rdata = '0;
  logic [3:0]  bus_req_mask;

  dmem_bus_bridge dut (
    .clk(clk), .rst(rst), .core_rd_en(core_rd_en), .core_wr_en(core_wr_en),
    .core_mask(core_mask), .core_addr(core_addr), .core_wr_data(core_wr_data),
    .core_rd_data(core_rd_data), .core_stall(core_stall), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_mask(bus_req_mask), .bus_resp_valid(bus_resp_valid),
    .bus_resp_rdata(bus_resp_rdata), .wbuf_empty(wbuf_empty)
  );

  always #5 clk = ~clk;

  typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask;} txn_t;
  txn_t        exp_bus[$];
  logic [31:0] exp_ld[$];
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  int          checks = 0, errors = 0;
  int          rdy_mode = 0, resp_delay = -1, resp_cnt = 0, n, n3;
  bit          outstanding = 0, spur_en = 0, prev_hold = 0, prev_we;
  logic [31:0] resp_data, prev_addr, prev_wdata;
  logic [3:0]  prev_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) if (rst) assert (!(core_rd_en && core_wr_en)) else $error("FAIL rd_wr_both");

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // bus agent: RAM model, ready/response driver and scoreboard monitor
  initial forever begin
    txn_t t;
    @(negedge clk);
    bus_req_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(3) != 0) : 1'b0;
    if (outstanding && resp_cnt > 0) begin
      resp_cnt--;
      bus_resp_valid = 1'b0;
    end else if (outstanding) begin
      bus_resp_valid = 1'b1;
      bus_resp_rdata = resp_data;
      outstanding = 0;
    end else begin
      bus_resp_valid = spur_en && $urandom_range(7) == 0;
      bus_resp_rdata = $urandom;
    end
    #4;
    if (!rst) prev_hold = 0;
    else begin
      if (prev_hold) begin
        chk("hold_valid", bus_req_valid, 1);
        chk("hold_we", bus_req_we, prev_we);
        chk("hold_addr", bus_req_addr, prev_addr);
        chk("hold_mask", bus_req_mask, prev_mask);
        if (prev_we) chk("hold_wdata", bus_req_wdata, prev_wdata);
      end
      prev_hold = bus_req_valid && !bus_req_ready;
      prev_we = bus_req_we; prev_addr = bus_req_addr; prev_wdata = bus_req_wdata; prev_mask = bus_req_mask;
      if (bus_req_valid && !bus_req_we) chk("read_before_drain", wbuf_empty, 1);
      if (bus_req_valid && bus_req_ready) begin
        if (exp_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_extra: got we=%b addr=%h expected no request", bus_req_we, bus_req_addr);
        end else begin
          t = exp_bus.pop_front();
          chk("bus_we", bus_req_we, t.we);
          chk("bus_addr", bus_req_addr, t.addr);
          chk("bus_mask", bus_req_mask, t.mask);
          if (t.we) chk("bus_wdata", bus_req_wdata, t.wdata);
        end
        if (bus_req_we) ram[bus_req_addr[9:2]] = merge(ram[bus_req_addr[9:2]], bus_req_wdata, bus_req_mask);
        else begin
          outstanding = 1;
          resp_cnt = resp_delay < 0 ? $urandom_range(3) : resp_delay;
          resp_data = ram[bus_req_addr[9:2]];
        end
      end
      if (core_rd_en && !core_wr_en && !core_stall) begin
        if (exp_ld.size() == 0) begin
          checks++; errors++;
          $display("FAIL load_extra: got %h expected no load completion", core_rd_data);
        end else chk("load_data", core_rd_data, exp_ld.pop_front());
      end
    end
  end

  task automatic core_op(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         output int stalls);
    txn_t t;
    bit   s;
    @(negedge clk);
    core_wr_en = we; core_rd_en = !we; core_addr = a; core_wr_data = d; core_mask = m;
    t.we = we; t.addr = {a[31:2], 2'b00}; t.wdata = d; t.mask = we ? m : 4'hF;
    exp_bus.push_back(t);
    if (we) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, m);
    else exp_ld.push_back(ref_mem[a[9:2]]);
    stalls = 0;
    forever begin
      #4;
      s = core_stall;
      @(posedge clk);
      if (!s) break;
      stalls++;
      if (stalls > 500) begin
        checks++; errors++;
        $display("FAIL op_timeout: got stall>500 cycles expected completion");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    core_rd_en = 1'b0; core_wr_en = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #4;
      if (wbuf_empty && !outstanding && exp_bus.size() == 0) return;
    end
    checks++; errors++;
    $display("FAIL drain_timeout: got pending=%0d expected 0", exp_bus.size());
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    repeat (2) @(negedge clk);
    #2;
    chk("rst_valid", bus_req_valid, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_rd_data", core_rd_data, 0);
    chk("rst_wbuf_empty", wbuf_empty, 1);
    @(negedge clk); rst = 1'b1;

    rdy_mode = 0;
    core_op(1, 32'h100, 32'hDEADBEEF, 4'hF, n);
    chk("t1_no_stall", n, 0);
    idle(); #4;
    chk("t1_bus_valid", bus_req_valid, 1);
    chk("t1_bus_we", bus_req_we, 1);
    chk("t1_bus_addr", bus_req_addr, 32'h100);
    @(negedge clk); #4;
    chk("t1_empty", wbuf_empty, 1);

    ram[65] = 32'h12345678; ref_mem[65] = 32'h12345678;
    resp_delay = 1;
    core_op(0, 32'h104, 0, 0, n);
    chk("t2_stall_cycles", n, 4);
    idle(); #4;
    chk("t2_rd_data", core_rd_data, 32'h12345678);
    chk("t2_stall_low", core_stall, 0);
    resp_delay = -1;

    rdy_mode = 2;
    core_op(1, 32'h010, 32'h11111111, 4'hF, n);
    chk("t3_st1_no_stall", n, 0);
    core_op(1, 32'h014, 32'h22222222, 4'h3, n);
    chk("t3_st2_no_stall", n, 0);
    fork
      core_op(1, 32'h018, 32'h33333333, 4'hC, n3);
      begin
        repeat (3) @(negedge clk);
        #4;
        chk("t3_st3_stall", core_stall, 1);
        chk("t3_not_empty", wbuf_empty, 0);
        rdy_mode = 0;
      end
    join
    chk("t3_st3_stalled", n3 >= 3, 1);
    idle(); wait_drain();

    rdy_mode = 1;
    core_op(1, 32'h200, 32'h000000A5, 4'hF, n);
    core_op(0, 32'h200, 0, 0, n);
    idle(); #4;
    chk("t4_load", core_rd_data, 32'hA5);

    rdy_mode = 0; resp_delay = 8;
    exp_bus.push_back('{we: 0, addr: 32'h140, wdata: 0, mask: 4'hF});
    @(negedge clk);
    core_rd_en = 1'b1; core_addr = 32'h140;
    repeat (3) @(negedge clk);
    #2; rst = 1'b0; core_rd_en = 1'b0;
    #1;
    chk("t5b_valid", bus_req_valid, 0);
    chk("t5b_stall", core_stall, 0);
    chk("t5b_rd_data", core_rd_data, 0);
    @(negedge clk); rst = 1'b1;
    repeat (12) @(negedge clk);
    #4;
    chk("t5b_ignore_resp", core_rd_data, 0);
    chk("t5b_idle_stall", core_stall, 0);
    chk("t5b_idle_valid", bus_req_valid, 0);
    resp_delay = -1;

    rdy_mode = 2;
    core_op(1, 32'h120, 32'hCAFEF00D, 4'hF, n);
    @(negedge clk);
    core_wr_en = 1'b0; core_rd_en = 1'b1; core_addr = 32'h130;
    @(negedge clk); #4;
    chk("t5a_drain_stall", core_stall, 1);
    chk("t5a_drain_valid", bus_req_valid, 1);
    @(negedge clk);
    #2; rst = 1'b0; core_rd_en = 1'b0;
    #1;
    chk("t5a_valid", bus_req_valid, 0);
    chk("t5a_stall", core_stall, 0);
    chk("t5a_empty", wbuf_empty, 1);
    exp_bus.delete();
    @(negedge clk); rst = 1'b1; rdy_mode = 0;
    repeat (2) @(negedge clk);
    #4;
    chk("t5a_no_write", bus_req_valid, 0);
    for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];

    rdy_mode = 2;
    fork
      core_op(0, 32'h0C6, 0, 0, n);
      begin
        for (int i = 0; i < 20 && !(bus_req_valid && !bus_req_we); i++) begin @(negedge clk); #4; end
        repeat (5) begin
          chk("t6_valid", bus_req_valid, 1);
          chk("t6_we", bus_req_we, 0);
          chk("t6_addr", bus_req_addr, 32'h0C4);
          chk("t6_mask", bus_req_mask, 4'hF);
          @(negedge clk); #4;
        end
        rdy_mode = 0;
      end
    join
    idle();

    spur_en = 1;
    for (int k = 0; k < 300; k++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(9);
      a = {22'd0, 8'($urandom_range(255)), 2'($urandom_range(3))};
      if (k % 40 == 0) rdy_mode = $urandom_range(1);
      if (r < 6) core_op(1, a, $urandom, 4'($urandom_range(1, 15)), n);
      else if (r < 9) core_op(0, a, 0, 0, n);
      else idle();
    end
    idle();
    wait_drain();
    chk("end_bus_queue", exp_bus.size(), 0);
    chk("end_load_queue", exp_ld.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
